// File: rtl/rf_port_ctrl.sv
// ============================================================================
// Module : rf_port_ctrl
// Brief  : RF write-port arbiter (core over PDU, with starvation hold) and
//          register-dump sequencer on the debug read port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rf_port_ctrl #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 5,
  parameter int STARVE_LIM = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cpu_we,
  input  logic [DEPTH-1:0] cpu_wa,
  input  logic [WIDTH-1:0] cpu_wd,
  output logic             cpu_hold,
  input  logic             pdu_wr_valid,
  output logic             pdu_wr_ready,
  input  logic [DEPTH-1:0] pdu_wa,
  input  logic [WIDTH-1:0] pdu_wd,
  input  logic             dump_start,
  output logic             dump_busy,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [DEPTH-1:0] dump_idx,
  output logic [WIDTH-1:0] dump_data,
  output logic             dump_done,
  output logic             rf_we,
  output logic [DEPTH-1:0] rf_wa,
  output logic [WIDTH-1:0] rf_wd,
  output logic [DEPTH-1:0] rf_ra_dbg,
  input  logic [WIDTH-1:0] rf_rd_dbg
);

  localparam int             c_CNT_W  = $clog2(STARVE_LIM + 1);
  localparam logic [c_CNT_W-1:0] c_LIM    = c_CNT_W'(STARVE_LIM);
  localparam logic [c_CNT_W-1:0] c_LIM_M1 = c_CNT_W'(STARVE_LIM - 1);
  localparam logic [DEPTH-1:0]   c_LAST   = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_t;

  logic               w_cpu_act;
  logic               w_stalled;
  logic [c_CNT_W-1:0] r_starve_cnt;
  state_t             r_state;
  state_t             w_state_nxt;
  logic [DEPTH-1:0]   r_idx;
  logic [DEPTH-1:0]   w_idx_nxt;
  logic               w_accept;

  // ---------------- write arbitration ----------------
  assign w_cpu_act    = cpu_we && (cpu_wa != '0);
  assign pdu_wr_ready = rstn && pdu_wr_valid && !w_cpu_act;
  assign w_stalled    = pdu_wr_valid && !pdu_wr_ready;

  always_comb begin
    rf_we = 1'b0;
    rf_wa = '0;
    rf_wd = '0;
    if (rstn) begin
      if (w_cpu_act) begin
        rf_we = 1'b1;
        rf_wa = cpu_wa;
        rf_wd = cpu_wd;
      end else if (pdu_wr_ready) begin
        // x0 writes complete the handshake but never reach the RF
        rf_we = (pdu_wa != '0);
        rf_wa = pdu_wa;
        rf_wd = pdu_wd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_starve_cnt <= '0;
      cpu_hold     <= 1'b0;
    end else begin
      if (!w_stalled) begin
        r_starve_cnt <= '0;
      end else if (r_starve_cnt != c_LIM) begin
        r_starve_cnt <= r_starve_cnt + c_CNT_W'(1);
      end
      cpu_hold <= ((r_starve_cnt == c_LIM_M1) && w_stalled) || (cpu_hold && !pdu_wr_ready);
    end
  end

  // ---------------- dump sequencer ----------------
  assign w_accept  = dump_valid && dump_ready;
  assign dump_busy = (r_state != S_IDLE);
  assign rf_ra_dbg = r_idx;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (dump_start) begin
          w_state_nxt = S_LOAD;
          w_idx_nxt   = '0;
        end
      end
      S_LOAD: w_state_nxt = S_SEND;
      S_SEND: begin
        if (w_accept) begin
          if (r_idx == c_LAST) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_LOAD;
            w_idx_nxt   = r_idx + DEPTH'(1);
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // The RF read port has no write bypass, so a same-cycle write is forwarded here
  always_ff @(posedge clk) begin
    if (!rstn) begin
      dump_valid <= 1'b0;
      dump_idx   <= '0;
      dump_data  <= '0;
      dump_done  <= 1'b0;
    end else begin
      dump_done <= (r_state == S_SEND) && w_accept && (r_idx == c_LAST);
      if (r_state == S_LOAD) begin
        dump_data  <= (rf_we && (rf_wa == r_idx)) ? rf_wd : rf_rd_dbg;
        dump_idx   <= r_idx;
        dump_valid <= 1'b1;
      end else if ((r_state == S_SEND) && w_accept) begin
        dump_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rf_port_ctrl.sv
// ============================================================================
// Module : tb_rf_port_ctrl
// Brief  : Self-checking bench for rf_port_ctrl with an RF model and a dump
//          scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rf_port_ctrl;
  localparam int WIDTH = 32;
  localparam int DEPTH = 5;
  localparam int NREG  = 32;

  logic             clk = 1'b0;
  logic             rstn;
  logic             cpu_we;
  logic [DEPTH-1:0] cpu_wa;
  logic [WIDTH-1:0] cpu_wd;
  logic             cpu_hold;
  logic             pdu_wr_valid;
  logic             pdu_wr_ready;
  logic [DEPTH-1:0] pdu_wa;
  logic [WIDTH-1:0] pdu_wd;
  logic             dump_start;
  logic             dump_busy;
  logic             dump_valid;
  logic             dump_ready;
  logic [DEPTH-1:0] dump_idx;
  logic [WIDTH-1:0] dump_data;
  logic             dump_done;
  logic             rf_we;
  logic [DEPTH-1:0] rf_wa;
  logic [WIDTH-1:0] rf_wd;
  logic [DEPTH-1:0] rf_ra_dbg;
  logic [WIDTH-1:0] rf_rd_dbg;

  always #5 clk = ~clk;

  rf_port_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .STARVE_LIM(8)) dut (
    .clk(clk), .rstn(rstn),
    .cpu_we(cpu_we), .cpu_wa(cpu_wa), .cpu_wd(cpu_wd), .cpu_hold(cpu_hold),
    .pdu_wr_valid(pdu_wr_valid), .pdu_wr_ready(pdu_wr_ready),
    .pdu_wa(pdu_wa), .pdu_wd(pdu_wd),
    .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data),
    .dump_done(dump_done),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .rf_ra_dbg(rf_ra_dbg), .rf_rd_dbg(rf_rd_dbg)
  );

  // Register file model: synchronous write, combinational read
  logic [WIDTH-1:0] rf_mem [NREG] = '{default: '0};
  always @(posedge clk) if (rf_we) rf_mem[rf_wa] <= rf_wd;
  assign rf_rd_dbg = rf_mem[rf_ra_dbg];

  logic [WIDTH-1:0]       exp_rf [NREG] = '{default: '0};
  logic [DEPTH+WIDTH-1:0] sb_q [$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_dump();
    for (int i = 0; i < NREG; i++) begin
      logic [DEPTH-1:0] ii;
      ii = i[DEPTH-1:0];
      sb_q.push_back({ii, exp_rf[i]});
    end
  endtask

  // A handshake seen here completes at the next rising edge
  always @(negedge clk) begin
    if (rstn && dump_valid && dump_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dump_extra got=%0h exp=none", {dump_idx, dump_data});
      end else begin
        check("dump_entry", {dump_idx, dump_data}, sb_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_at;
    int held;
    bit w9;
    bit found;
    bit seen;

    rstn = 1'b0; cpu_we = 1'b1; cpu_wa = 5'd3; cpu_wd = 32'h33;
    pdu_wr_valid = 1'b1; pdu_wa = 5'd4; pdu_wd = 32'h44;
    dump_start = 1'b0; dump_ready = 1'b0;
    step(); step();
    check("rst_rf_we", rf_we, 0);
    check("rst_ready", pdu_wr_ready, 0);
    check("rst_hold", cpu_hold, 0);
    check("rst_busy", dump_busy, 0);
    check("rst_valid", dump_valid, 0);
    check("rst_idx_data", {dump_idx, dump_data}, 0);
    check("rst_done", dump_done, 0);
    cpu_we = 1'b0; pdu_wr_valid = 1'b0; rstn = 1'b1;
    step();

    // core wins over PDU, PDU follows
    cpu_we = 1'b1; cpu_wa = 5'd5; cpu_wd = 32'hA5;
    pdu_wr_valid = 1'b1; pdu_wa = 5'd6; pdu_wd = 32'h66;
    #1;
    check("t1_we", rf_we, 1);
    check("t1_wa_wd", {rf_wa, rf_wd}, {5'd5, 32'hA5});
    check("t1_ready", pdu_wr_ready, 0);
    exp_rf[5] = 32'hA5;
    step();
    cpu_we = 1'b0;
    #1;
    check("t1_pdu_wa_wd", {rf_we, rf_wa, rf_wd}, {1'b1, 5'd6, 32'h66});
    check("t1_pdu_ready", pdu_wr_ready, 1);
    exp_rf[6] = 32'h66;
    step();

    // core write to x0 is not an activity; PDU x0 handshakes without a write
    cpu_we = 1'b1; cpu_wa = 5'd0; cpu_wd = 32'hDEAD;
    pdu_wa = 5'd7; pdu_wd = 32'h1234;
    #1;
    check("t2_ready", pdu_wr_ready, 1);
    check("t2_wa_wd", {rf_we, rf_wa, rf_wd}, {1'b1, 5'd7, 32'h1234});
    exp_rf[7] = 32'h1234;
    step();
    cpu_we = 1'b0; pdu_wa = 5'd0; pdu_wd = 32'hBEEF;
    #1;
    check("t2_x0_ready", pdu_wr_ready, 1);
    check("t2_x0_we", rf_we, 0);
    step();
    pdu_wr_valid = 1'b0;
    step();

    // starvation: hold visible from stall cycle 9
    cpu_we = 1'b1; cpu_wa = 5'd1; cpu_wd = 32'h11;
    pdu_wr_valid = 1'b1; pdu_wa = 5'd8; pdu_wd = 32'h88;
    exp_rf[1] = 32'h11;
    for (int k = 1; k <= 10; k++) begin
      #1;
      check($sformatf("t3_hold_c%0d", k), cpu_hold, (k >= 9));
      step();
    end
    cpu_we = 1'b0;
    #1;
    check("t3_grant", {pdu_wr_ready, cpu_hold}, 2'b11);
    exp_rf[8] = 32'h88;
    step();
    pdu_wr_valid = 1'b0;
    #1;
    check("t3_hold_fall", cpu_hold, 0);

    // full dump with dump_ready high
    cpu_we = 1'b1; cpu_wa = 5'd2; cpu_wd = 32'h2ffc; exp_rf[2] = 32'h2ffc;
    step();
    cpu_wa = 5'd3; cpu_wd = 32'h1800; exp_rf[3] = 32'h1800;
    step();
    cpu_we = 1'b0;
    push_dump();
    dump_ready = 1'b1; dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    check("t4_busy", dump_busy, 1);
    done_at = 0;
    for (int n = 1; n <= 80; n++) begin
      step();
      dump_start = (n == 10);
      if (dump_done) begin
        done_at = n;
        break;
      end
    end
    dump_start = 1'b0;
    // 64 edges after the start edge = cycle 65 counting the start edge as 1
    check("t4_done_cycle", done_at, 64);
    step();
    check("t4_done_pulse", {dump_done, dump_busy}, 2'b00);
    check("t4_sb_empty", sb_q.size(), 0);

    // backpressure on idx 4, bypassed write on idx 9 LOAD
    exp_rf[9] = 32'h55;
    push_dump();
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    held = 0; w9 = 1'b0; done_at = 0;
    for (int n = 1; n <= 120; n++) begin
      step();
      cpu_we = 1'b0;
      if (dump_done) begin
        done_at = n;
        break;
      end
      if (dump_valid && dump_idx == 5'd4 && held < 5) begin
        check("t5_stable", {dump_valid, dump_idx, dump_data}, {1'b1, 5'd4, exp_rf[4]});
        dump_ready = 1'b0;
        held++;
      end else begin
        dump_ready = 1'b1;
      end
      if (!w9 && dump_busy && !dump_valid && rf_ra_dbg == 5'd9) begin
        cpu_we = 1'b1; cpu_wa = 5'd9; cpu_wd = 32'h55;
        w9 = 1'b1;
      end
    end
    cpu_we = 1'b0;
    check("t5_finished", done_at != 0, 1);
    check("t5_held", held, 5);
    check("t5_sb_empty", sb_q.size(), 0);
    step();

    // reset during SEND of idx 10 abandons the dump; hold also cleared
    push_dump();
    dump_ready = 1'b1; dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    cpu_we = 1'b1; cpu_wa = 5'd1; cpu_wd = 32'h11;
    pdu_wr_valid = 1'b1; pdu_wa = 5'd8; pdu_wd = 32'h88;
    found = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      step();
      if (dump_valid && dump_idx == 5'd10) begin
        dump_ready = 1'b0;
        found = 1'b1;
        break;
      end
    end
    check("t6_reached_idx10", found, 1);
    check("t6_hold_pre", cpu_hold, 1);
    rstn = 1'b0; cpu_we = 1'b0; pdu_wr_valid = 1'b0;
    step();
    check("t6_after_rst", {dump_busy, dump_valid, cpu_hold, dump_done}, 4'b0000);
    sb_q.delete();
    rstn = 1'b1; dump_ready = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 6; n++) begin
      step();
      if (dump_done || dump_valid) seen = 1'b1;
    end
    check("t6_no_done", seen, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
